// File: rtl/keypad_scanner_if.sv
// Keypad matrix signals plus the key-code/strobe path toward the classifier.
// The scanner drives the columns and key outputs; the keypad side drives the rows.
interface keypad_scanner_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates a low column, debounces press/release on the latched
// row and emits one key code with a single-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DB_COUNT = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_scanner_if.master   kp
);

  localparam int DW_W = $clog2(SCAN_DIV);
  localparam int DB_W = $clog2(DB_COUNT);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_meta_q, row_s_q;
  logic [1:0]      col_q, col_d;
  logic [3:0]      col_n_q, col_n_d;
  logic [1:0]      row_sel_q, row_sel_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [DB_W-1:0] db_q, db_d;
  logic            pend_q, pend_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            row_low_s;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Multiple keys in one column: the lowest-index low row wins.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  assign row_low_s = ~row_s_q[row_sel_q];

  // Next-state and output logic for the scan/debounce/hold machine.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_sel_d   = row_sel_q;
    dwell_d     = dwell_q;
    db_d        = db_q;
    pend_d      = 1'b0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    // Code, strobe and held flag land one edge after the press is accepted.
    if (pend_q) begin
      key_code_d  = key_map(row_sel_q, col_q);
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end else begin
      key_held_d  = key_held_q;
    end

    case (state_q)
      SCAN: begin
        if (dwell_q == DW_LAST) begin
          if (row_s_q != 4'b1111) begin
            state_d   = DEBOUNCE;
            row_sel_d = lowest_low(row_s_q);
            db_d      = {DB_W{1'b0}};
          end else begin
            col_d     = col_q + 2'd1;
            dwell_d   = {DW_W{1'b0}};
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      DEBOUNCE: begin
        if (row_low_s) begin
          if (db_q == DB_LAST) begin
            state_d = HELD;
            db_d    = {DB_W{1'b0}};
            pend_d  = 1'b1;
          end else begin
            db_d    = db_q + DB_W'(1);
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = {DW_W{1'b0}};
        end
      end
      HELD: begin
        if (!row_low_s) begin
          if (db_q == DB_LAST) begin
            state_d    = SCAN;
            col_d      = col_q + 2'd1;
            dwell_d    = {DW_W{1'b0}};
            db_d       = {DB_W{1'b0}};
            key_held_d = 1'b0;
          end else begin
            db_d       = db_q + DB_W'(1);
          end
        end else begin
          db_d = {DB_W{1'b0}};
        end
      end
      default: begin
        state_d    = SCAN;
        col_d      = 2'd0;
        dwell_d    = {DW_W{1'b0}};
        db_d       = {DB_W{1'b0}};
        key_held_d = 1'b0;
      end
    endcase

    case (col_d)
      2'd0:    col_n_d = 4'b1110;
      2'd1:    col_n_d = 4'b1101;
      2'd2:    col_n_d = 4'b1011;
      2'd3:    col_n_d = 4'b0111;
      default: col_n_d = 4'b1110;
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      row_meta_q  <= 4'b1111;
      row_s_q     <= 4'b1111;
      col_q       <= 2'd0;
      col_n_q     <= 4'b1110;
      row_sel_q   <= 2'd0;
      dwell_q     <= {DW_W{1'b0}};
      db_q        <= {DB_W{1'b0}};
      pend_q      <= 1'b0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_meta_q  <= kp.row_n;
      row_s_q     <= row_meta_q;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      row_sel_q   <= row_sel_d;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      pend_q      <= pend_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model: a pressed key pulls its
// row low only while its column is driven low.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB_COUNT = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] pressed;     // bit r*4+c
  int          checks;
  int          errors;
  int          strobes;
  logic [3:0]  last_code;
  int          base;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DB_COUNT (DB_COUNT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    kif.row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kif.col_n[c]) begin
          kif.row_n[r] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && kif.key_valid) begin
      strobes   = strobes + 1;
      last_code = kif.key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_check(input string tag, input int r, input int c, input logic [3:0] code);
    base = strobes;
    pressed[r*4+c] = 1'b1;
    idle(60);
    check({tag, "_strobes"}, 32'(strobes - base), 32'd1);
    check({tag, "_code"}, {28'd0, last_code}, {28'd0, code});
    pressed[r*4+c] = 1'b0;
    idle(40);
    check({tag, "_released"}, {31'd0, kif.key_held}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    strobes   = 0;
    last_code = 4'h0;
    pressed   = 16'h0000;
    rst_n     = 1'b0;

    // 1: reset values and column rotation
    idle(3);
    check("rst_col", {28'd0, kif.col_n}, 32'h0000_000E);
    check("rst_code", {28'd0, kif.key_code}, 32'd0);
    check("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    check("rst_held", {31'd0, kif.key_held}, 32'd0);
    rst_n = 1'b1;
    check("col_0", {28'd0, kif.col_n}, 32'h0000_000E);
    idle(SCAN_DIV);
    check("col_1", {28'd0, kif.col_n}, 32'h0000_000D);
    idle(SCAN_DIV);
    check("col_2", {28'd0, kif.col_n}, 32'h0000_000B);
    idle(SCAN_DIV);
    check("col_3", {28'd0, kif.col_n}, 32'h0000_0007);
    idle(SCAN_DIV);
    check("col_wrap", {28'd0, kif.col_n}, 32'h0000_000E);
    check("idle_strobes", 32'(strobes), 32'd0);

    // 2: clean press of '5', exact release timing
    base = strobes;
    pressed[1*4+1] = 1'b1;
    idle(200);
    check("p5_strobes", 32'(strobes - base), 32'd1);
    check("p5_code", {28'd0, last_code}, 32'h5);
    check("p5_held", {31'd0, kif.key_held}, 32'd1);
    pressed[1*4+1] = 1'b0;
    idle(9);
    check("p5_held_late", {31'd0, kif.key_held}, 32'd1);
    check("p5_col_held", {28'd0, kif.col_n}, 32'h0000_000D);
    idle(1);
    check("p5_rel", {31'd0, kif.key_held}, 32'd0);
    check("p5_col_next", {28'd0, kif.col_n}, 32'h0000_000B);
    idle(30);

    // 3: bouncing '1' then steady
    base = strobes;
    for (int i = 0; i < 8; i++) begin
      pressed[0] = 1'b1;
      idle(3);
      pressed[0] = 1'b0;
      idle(2);
    end
    check("bounce_none", 32'(strobes - base), 32'd0);
    pressed[0] = 1'b1;
    idle(100);
    check("bounce_strobes", 32'(strobes - base), 32'd1);
    check("bounce_code", {28'd0, last_code}, 32'h1);
    pressed[0] = 1'b0;
    idle(40);

    // 4: long hold of 'C'
    base = strobes;
    pressed[2*4+3] = 1'b1;
    idle(5000);
    check("c_strobes", 32'(strobes - base), 32'd1);
    check("c_held", {31'd0, kif.key_held}, 32'd1);
    pressed[2*4+3] = 1'b0;
    idle(40);
    check("c_code_kept", {28'd0, kif.key_code}, 32'hC);
    check("c_rel", {31'd0, kif.key_held}, 32'd0);

    // 5: map corners and same-column priority
    press_check("star", 3, 0, 4'hE);
    press_check("zero", 3, 1, 4'h0);
    press_check("hash", 3, 2, 4'hF);
    press_check("keyD", 3, 3, 4'hD);
    press_check("keyA", 0, 3, 4'hA);
    base = strobes;
    pressed[0*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    idle(60);
    check("dual_strobes", 32'(strobes - base), 32'd1);
    check("dual_code", {28'd0, last_code}, 32'h1);
    pressed = 16'h0000;
    idle(40);

    // 6: reset during HELD on '9'
    base = strobes;
    pressed[2*4+2] = 1'b1;
    idle(60);
    check("r9_strobes", 32'(strobes - base), 32'd1);
    check("r9_held", {31'd0, kif.key_held}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("r9_held_drop", {31'd0, kif.key_held}, 32'd0);
    check("r9_col", {28'd0, kif.col_n}, 32'h0000_000E);
    check("r9_code_rst", {28'd0, kif.key_code}, 32'd0);
    idle(3);
    check("r9_no_strobe", 32'(strobes - base), 32'd1);
    rst_n = 1'b1;
    idle(60);
    check("r9_again", 32'(strobes - base), 32'd2);
    check("r9_code", {28'd0, last_code}, 32'h9);
    pressed = 16'h0000;
    idle(40);
    check("r9_rel", {31'd0, kif.key_held}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
